// File: rtl/onchip_mem_pkg.sv
// ---------------------------------------------------------------------------
// onchip_mem_pkg
// Shared types and defaults for the dual-port arbitrated on-chip memory.
//   port_id_t  : identifies which Avalon-style slave port won an access
//   DATA_W_DEF : default data width in bits (multiple of 8)
//   ADDR_W_DEF : default word-address width (depth = 2**ADDR_W words)
//   other_port : returns the opposite port id (used for tie-breaking)
// ---------------------------------------------------------------------------
package onchip_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [0:0] {
        PORT_S1 = 1'b0,
        PORT_S2 = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        port_id_t o;
        case (p)
            PORT_S1: o = PORT_S2;
            PORT_S2: o = PORT_S1;
            default: o = PORT_S1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/nios_system_onchip_memory_arb_if.sv
// ---------------------------------------------------------------------------
// nios_system_onchip_memory_arb_if
// One memory-mapped slave port of the on-chip memory.
//   address       word address                      (master -> slave)
//   byteenable    write byte lanes                  (master -> slave)
//   read / write  request strobes                   (master -> slave)
//   writedata     write data                        (master -> slave)
//   readdata      registered read data              (slave -> master)
//   readdatavalid readdata valid this cycle         (slave -> master)
//   waitrequest   request not accepted this cycle   (slave -> master)
// ---------------------------------------------------------------------------
interface nios_system_onchip_memory_arb_if
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/onchip_mem_rr_arb.sv
// ---------------------------------------------------------------------------
// onchip_mem_rr_arb
// Two-requester arbiter for the shared single-port RAM. Grants are
// combinational (a lone requester is granted in the same cycle) and are
// one-hot or zero.
//   clk, reset_n     : clock, asynchronous active-low reset
//   req_1, req_2     : access requests from port 1 / port 2
//   grant_1, grant_2 : access granted to port 1 / port 2
// Build option OCM_ARB_FIXED_PRIO_EN: port 1 always wins ties and the
// last-grant pointer is removed (port 2 may starve). Default: round-robin,
// pointer resets to port 2 so port 1 wins the first tie.
// ---------------------------------------------------------------------------
module onchip_mem_rr_arb
    import onchip_mem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_1,
    input  logic req_2,
    output logic grant_1,
    output logic grant_2
);

`ifdef OCM_ARB_FIXED_PRIO_EN

    // clk/reset_n are kept in the port list so both builds share one footprint
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk ^ reset_n;

    // Fixed priority: port 1 wins whenever it asks
    always_comb begin
        grant_1 = req_1;
        grant_2 = req_2 & ~req_1;
    end

`else

    port_id_t last_grant_r;

    // Round-robin: on a tie the port that did not win most recently is served
    always_comb begin
        grant_1 = 1'b0;
        grant_2 = 1'b0;
        if (req_1 && req_2) begin
            if (other_port(last_grant_r) == PORT_S1) begin
                grant_1 = 1'b1;
            end else begin
                grant_2 = 1'b1;
            end
        end else begin
            grant_1 = req_1;
            grant_2 = req_2;
        end
    end

    // Pointer remembers the winner of every grant, contested or not
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= PORT_S2;
        end else if (grant_1) begin
            last_grant_r <= PORT_S1;
        end else if (grant_2) begin
            last_grant_r <= PORT_S2;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

`endif

endmodule

// File: rtl/nios_system_onchip_memory_arb.sv
// ---------------------------------------------------------------------------
// nios_system_onchip_memory_arb
// Single-port on-chip RAM shared by two slave ports, at most one access per
// cycle. Writes update enabled byte lanes at the next clock edge; reads have
// a fixed latency of one cycle. A request with read and write both high is a
// write only.
//   clk      : single clock
//   reset_n  : asynchronous active-low reset (clears read pipeline and read
//              data, never the RAM contents)
//   s1, s2   : slave ports (see nios_system_onchip_memory_arb_if)
// Build option OCM_ARB_FIXED_PRIO_EN selects fixed port-1 priority instead
// of round-robin arbitration (handled in onchip_mem_rr_arb).
// ---------------------------------------------------------------------------
module nios_system_onchip_memory_arb
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                               clk,
    input  logic                               reset_n,
    nios_system_onchip_memory_arb_if.slave     s1,
    nios_system_onchip_memory_arb_if.slave     s2
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              req_1_s;
    logic              req_2_s;
    logic              grant_1_s;
    logic              grant_2_s;
    logic [ADDR_W-1:0] addr_s;
    logic [BE_W-1:0]   be_s;
    logic [DATA_W-1:0] wdata_s;
    logic              wr_en_s;
    logic              rd_1_s;
    logic              rd_2_s;

    logic [DATA_W-1:0] s1_readdata_r;
    logic [DATA_W-1:0] s2_readdata_r;
    logic              s1_rdv_r;
    logic              s2_rdv_r;

    assign req_1_s = s1.read | s1.write;
    assign req_2_s = s2.read | s2.write;

    onchip_mem_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_1   (req_1_s),
        .req_2   (req_2_s),
        .grant_1 (grant_1_s),
        .grant_2 (grant_2_s)
    );

    // Steer the granted port onto the RAM; write wins over read on one port
    always_comb begin
        addr_s  = s1.address;
        be_s    = s1.byteenable;
        wdata_s = s1.writedata;
        wr_en_s = 1'b0;
        if (grant_2_s) begin
            addr_s  = s2.address;
            be_s    = s2.byteenable;
            wdata_s = s2.writedata;
            wr_en_s = s2.write;
        end else begin
            wr_en_s = grant_1_s & s1.write;
        end
        rd_1_s = grant_1_s & s1.read & ~s1.write;
        rd_2_s = grant_2_s & s2.read & ~s2.write;
    end

    // RAM byte-lane write; suppressed while reset is held so stray grants
    // during reset cannot corrupt contents
    always_ff @(posedge clk) begin
        if (reset_n && wr_en_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_s[b]) begin
                    mem_r[addr_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
                end
            end
        end
    end

    // One-cycle read pipeline; readdata holds between valid pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_rdv_r      <= 1'b0;
            s2_rdv_r      <= 1'b0;
            s1_readdata_r <= {DATA_W{1'b0}};
            s2_readdata_r <= {DATA_W{1'b0}};
        end else begin
            s1_rdv_r <= rd_1_s;
            s2_rdv_r <= rd_2_s;
            if (rd_1_s) begin
                s1_readdata_r <= mem_r[addr_s];
            end
            if (rd_2_s) begin
                s2_readdata_r <= mem_r[addr_s];
            end
        end
    end

    assign s1.readdata      = s1_readdata_r;
    assign s1.readdatavalid = s1_rdv_r;
    assign s1.waitrequest   = req_1_s & ~grant_1_s;
    assign s2.readdata      = s2_readdata_r;
    assign s2.readdatavalid = s2_rdv_r;
    assign s2.waitrequest   = req_2_s & ~grant_2_s;

endmodule

// File: tb/tb_nios_system_onchip_memory_arb.sv
// ---------------------------------------------------------------------------
// tb_nios_system_onchip_memory_arb
// Directed self-checking bench for nios_system_onchip_memory_arb.
// Inputs are driven 1 time unit after the rising edge; registered outputs
// are sampled there, combinational waitrequest 1 unit after driving.
// ---------------------------------------------------------------------------
module tb_nios_system_onchip_memory_arb;
    import onchip_mem_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    int   s1_rdv_cnt;
    int   s2_rdv_cnt;
    logic exp_w1;
    logic exp_w2;

    always #5 clk = ~clk;

    nios_system_onchip_memory_arb_if #(.DATA_W(32), .ADDR_W(12)) s1_bus ();
    nios_system_onchip_memory_arb_if #(.DATA_W(32), .ADDR_W(12)) s2_bus ();

    nios_system_onchip_memory_arb #(.DATA_W(32), .ADDR_W(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s1      (s1_bus),
        .s2      (s2_bus)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s1(input logic rd, input logic wr, input logic [11:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        s1_bus.read       = rd;
        s1_bus.write      = wr;
        s1_bus.address    = a;
        s1_bus.byteenable = be;
        s1_bus.writedata  = d;
    endtask

    task automatic drive_s2(input logic rd, input logic wr, input logic [11:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        s2_bus.read       = rd;
        s2_bus.write      = wr;
        s2_bus.address    = a;
        s2_bus.byteenable = be;
        s2_bus.writedata  = d;
    endtask

    task automatic bus_idle();
        drive_s1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        drive_s2(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state, with both ports requesting during reset
        reset_n = 1'b0;
        bus_idle();
        drive_s1(1'b1, 1'b0, 12'h000, 4'h0, 32'h0);
        drive_s2(1'b1, 1'b0, 12'h000, 4'h0, 32'h0);
        step();
        check_val("rst_s1_wait", 32'(s1_bus.waitrequest), 32'd0);
        check_val("rst_s2_wait", 32'(s2_bus.waitrequest), 32'd1);
        check_val("rst_s1_rdv", 32'(s1_bus.readdatavalid), 32'd0);
        check_val("rst_s2_rdv", 32'(s2_bus.readdatavalid), 32'd0);
        check_val("rst_s1_rdata", s1_bus.readdata, 32'h0);
        check_val("rst_s2_rdata", s2_bus.readdata, 32'h0);
        bus_idle();
        reset_n = 1'b1;
        step();
        check_val("post_rst_s1_rdv", 32'(s1_bus.readdatavalid), 32'd0);

        // s1 write then s2 read of the same word on the next cycle
        drive_s1(1'b0, 1'b1, 12'h005, 4'hF, 32'hDEADBEEF);
        #1;
        check_val("wr5_s1_wait", 32'(s1_bus.waitrequest), 32'd0);
        step();
        drive_s1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        drive_s2(1'b1, 1'b0, 12'h005, 4'h0, 32'h0);
        #1;
        check_val("rd5_s2_wait", 32'(s2_bus.waitrequest), 32'd0);
        step();
        check_val("rd5_s2_rdv", 32'(s2_bus.readdatavalid), 32'd1);
        check_val("rd5_s2_rdata", s2_bus.readdata, 32'hDEADBEEF);
        check_val("rd5_s1_rdv", 32'(s1_bus.readdatavalid), 32'd0);
        bus_idle();
        step();
        check_val("rd5_s2_rdv_drop", 32'(s2_bus.readdatavalid), 32'd0);
        check_val("rd5_s2_rdata_hold", s2_bus.readdata, 32'hDEADBEEF);

        // Partial byte-lane write
        drive_s1(1'b0, 1'b1, 12'h010, 4'hF, 32'h11223344);
        step();
        drive_s1(1'b0, 1'b1, 12'h010, 4'h5, 32'hAABBCCDD);
        step();
        drive_s1(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        step();
        check_val("be_s1_rdv", 32'(s1_bus.readdatavalid), 32'd1);
        check_val("be_s1_rdata", s1_bus.readdata, 32'h11BB33DD);
        bus_idle();
        step();

        // Read+write together on s2 acts as a write only
        drive_s2(1'b1, 1'b1, 12'h020, 4'hF, 32'h0000CAFE);
        step();
        check_val("rw_s2_no_rdv", 32'(s2_bus.readdatavalid), 32'd0);
        drive_s2(1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        step();
        check_val("rw_s2_rdv", 32'(s2_bus.readdatavalid), 32'd1);
        check_val("rw_s2_rdata", s2_bus.readdata, 32'h0000CAFE);
        bus_idle();
        step();

        // Both ports read every cycle for 8 cycles (last winner was s2)
        drive_s1(1'b1, 1'b0, 12'h005, 4'h0, 32'h0);
        drive_s2(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        s1_rdv_cnt = 0;
        s2_rdv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef OCM_ARB_FIXED_PRIO_EN
            exp_w1 = 1'b0;
            exp_w2 = 1'b1;
`else
            exp_w1 = (i % 2) == 1;
            exp_w2 = (i % 2) == 0;
`endif
            check_val($sformatf("tie_s1_wait_%0d", i), 32'(s1_bus.waitrequest), 32'(exp_w1));
            check_val($sformatf("tie_s2_wait_%0d", i), 32'(s2_bus.waitrequest), 32'(exp_w2));
            step();
            s1_rdv_cnt += int'(s1_bus.readdatavalid);
            s2_rdv_cnt += int'(s2_bus.readdatavalid);
        end
`ifdef OCM_ARB_FIXED_PRIO_EN
        check_val("tie_s1_rdv_cnt", 32'(s1_rdv_cnt), 32'd8);
        check_val("tie_s2_rdv_cnt", 32'(s2_rdv_cnt), 32'd0);
`else
        check_val("tie_s1_rdv_cnt", 32'(s1_rdv_cnt), 32'd4);
        check_val("tie_s2_rdv_cnt", 32'(s2_rdv_cnt), 32'd4);
`endif
        bus_idle();
        step();

        // Back-to-back reads on s1 give back-to-back valid pulses
        drive_s1(1'b1, 1'b0, 12'h005, 4'h0, 32'h0);
        step();
        check_val("b2b_rdv_0", 32'(s1_bus.readdatavalid), 32'd1);
        check_val("b2b_rdata_0", s1_bus.readdata, 32'hDEADBEEF);
        drive_s1(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        step();
        check_val("b2b_rdv_1", 32'(s1_bus.readdatavalid), 32'd1);
        check_val("b2b_rdata_1", s1_bus.readdata, 32'h11BB33DD);
        drive_s1(1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        step();
        check_val("b2b_rdv_2", 32'(s1_bus.readdatavalid), 32'd1);
        check_val("b2b_rdata_2", s1_bus.readdata, 32'h0000CAFE);
        bus_idle();
        step();
        check_val("b2b_rdv_end", 32'(s1_bus.readdatavalid), 32'd0);

        // Reset in the cycle of an s1 read grant; RAM survives reset
        drive_s2(1'b0, 1'b1, 12'h030, 4'hF, 32'h0BADF00D);
        step();
        bus_idle();
        drive_s1(1'b1, 1'b0, 12'h005, 4'h0, 32'h0);
        #2;
        reset_n = 1'b0;
        check_val("rst2_s1_wait", 32'(s1_bus.waitrequest), 32'd0);
        step();
        check_val("rst2_s1_rdv", 32'(s1_bus.readdatavalid), 32'd0);
        check_val("rst2_s1_rdata", s1_bus.readdata, 32'h0);
        drive_s1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        drive_s2(1'b0, 1'b1, 12'h030, 4'hF, 32'hFFFFFFFF);
        #1;
        check_val("rst2_s2_wait", 32'(s2_bus.waitrequest), 32'd0);
        step();
        bus_idle();
        reset_n = 1'b1;
        step();
        check_val("rel_s1_rdv", 32'(s1_bus.readdatavalid), 32'd0);
        check_val("rel_s2_rdv", 32'(s2_bus.readdatavalid), 32'd0);
        drive_s1(1'b1, 1'b0, 12'h005, 4'h0, 32'h0);
        drive_s2(1'b1, 1'b0, 12'h030, 4'h0, 32'h0);
        #1;
        check_val("rel_tie_s1_wait", 32'(s1_bus.waitrequest), 32'd0);
        check_val("rel_tie_s2_wait", 32'(s2_bus.waitrequest), 32'd1);
        step();
        check_val("rel_s1_rdv1", 32'(s1_bus.readdatavalid), 32'd1);
        check_val("rel_s1_rdata", s1_bus.readdata, 32'hDEADBEEF);
        drive_s1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        #1;
        check_val("rel_s2_wait", 32'(s2_bus.waitrequest), 32'd0);
        step();
        check_val("rel_s2_rdv1", 32'(s2_bus.readdatavalid), 32'd1);
        check_val("rel_s2_rdata", s2_bus.readdata, 32'h0BADF00D);
        bus_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
